// File: rtl/tdc_mc_core.sv
// Multi-channel TDC: timestamps synchronised hit edges and round-robins them into a FWFT word FIFO.
// Optional macro TDC_FALLING_EDGE_EN adds falling-edge capture with a second pending entry per channel.
module tdc_mc_core #(
  parameter int CHANNELS   = 4,
  parameter int TS_WIDTH   = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int LOST_WIDTH = 16,
  localparam int CH_BITS   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int WORD_W    = CH_BITS + 1 + TS_WIDTH
) (
  input  logic                  BUS_CLK,
  input  logic                  BUS_RST,
  input  logic                  TS_RESET,
  input  logic [CHANNELS-1:0]   ENABLE,
  input  logic [CHANNELS-1:0]   SIGNAL,
  output logic [WORD_W-1:0]     DATA_OUT,
  output logic                  DATA_VALID,
  input  logic                  DATA_READY,
  output logic                  FIFO_FULL,
  output logic [LOST_WIDTH-1:0] LOST_CNT,
  output logic [TS_WIDTH-1:0]   TS_VALUE
);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int DROP_W = $clog2(2 * CHANNELS + 1);

  logic [CHANNELS-1:0] sync_q1, sync_q2, sync_q3;
  logic [CHANNELS-1:0] rise_det, rise_pend, clr_rise, drop_rise;
  logic [CHANNELS-1:0] fall_pend, pend_any;
  logic [TS_WIDTH-1:0] rise_ts [CHANNELS];
  logic                gnt_valid, gnt_rise, pop, can_push;
  logic [CH_BITS-1:0]  gnt_ch, ptr, ptr_nxt;
  logic [WORD_W-1:0]   gnt_word;
  logic [DROP_W-1:0]   drop_n;
  logic [LOST_WIDTH:0] lost_sum;
  logic [WORD_W-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         count, count_nxt;
  int                  idx;

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      sync_q1  <= '0;
      sync_q2  <= '0;
      sync_q3  <= '0;
      TS_VALUE <= '0;
    end else begin
      sync_q1  <= SIGNAL;
      sync_q2  <= sync_q1;
      sync_q3  <= sync_q2;
      TS_VALUE <= TS_RESET ? '0 : TS_VALUE + TS_WIDTH'(1);
    end
  end

  assign rise_det  = sync_q2 & ~sync_q3 & ENABLE;
  assign drop_rise = rise_det & rise_pend & ~clr_rise;

  // An entry granted in the same cycle frees its slot, so a new edge then loads instead of dropping.
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      rise_pend <= '0;
      for (int i = 0; i < CHANNELS; i++) rise_ts[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (rise_det[i] && !(rise_pend[i] && !clr_rise[i])) begin
          rise_pend[i] <= 1'b1;
          rise_ts[i]   <= TS_VALUE;
        end else if (clr_rise[i]) begin
          rise_pend[i] <= 1'b0;
        end
      end
    end
  end

`ifdef TDC_FALLING_EDGE_EN
  logic [CHANNELS-1:0] fall_det, clr_fall, drop_fall;
  logic [TS_WIDTH-1:0] fall_ts [CHANNELS];

  assign fall_det  = ~sync_q2 & sync_q3 & ENABLE;
  assign drop_fall = fall_det & fall_pend & ~clr_fall;
  assign gnt_rise  = rise_pend[gnt_ch];
  assign gnt_word  = {gnt_ch, gnt_rise, gnt_rise ? rise_ts[gnt_ch] : fall_ts[gnt_ch]};

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      fall_pend <= '0;
      for (int i = 0; i < CHANNELS; i++) fall_ts[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (fall_det[i] && !(fall_pend[i] && !clr_fall[i])) begin
          fall_pend[i] <= 1'b1;
          fall_ts[i]   <= TS_VALUE;
        end else if (clr_fall[i]) begin
          fall_pend[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    clr_rise = '0;
    clr_fall = '0;
    if (gnt_valid) begin
      if (gnt_rise) clr_rise[gnt_ch] = 1'b1;
      else          clr_fall[gnt_ch] = 1'b1;
    end
  end

  always_comb begin
    drop_n = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (drop_rise[i]) drop_n = drop_n + DROP_W'(1);
      if (drop_fall[i]) drop_n = drop_n + DROP_W'(1);
    end
  end
`else
  assign fall_pend = '0;
  assign gnt_rise  = 1'b1;
  assign gnt_word  = {gnt_ch, 1'b1, rise_ts[gnt_ch]};

  always_comb begin
    clr_rise = '0;
    if (gnt_valid) clr_rise[gnt_ch] = 1'b1;
  end

  always_comb begin
    drop_n = '0;
    for (int i = 0; i < CHANNELS; i++)
      if (drop_rise[i]) drop_n = drop_n + DROP_W'(1);
  end
`endif

  assign pend_any = rise_pend | fall_pend;
  assign pop      = DATA_VALID & DATA_READY;
  // A full FIFO still takes a word when the head is leaving in the same cycle.
  assign can_push = !FIFO_FULL || pop;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_ch    = '0;
    idx       = 0;
    for (int i = 0; i < CHANNELS; i++) begin
      idx = int'(ptr) + i;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!gnt_valid && can_push && pend_any[idx]) begin
        gnt_valid = 1'b1;
        gnt_ch    = CH_BITS'(idx);
      end
    end
  end

  // Holding the pointer after a rising grant lets the same channel's falling entry go next.
  always_comb begin
    ptr_nxt = ptr;
    if (gnt_valid) begin
      if (gnt_ch == CH_BITS'(CHANNELS - 1)) ptr_nxt = '0;
      else                                  ptr_nxt = gnt_ch + CH_BITS'(1);
      if (gnt_rise && fall_pend[gnt_ch])    ptr_nxt = gnt_ch;
    end
  end

  always_comb begin
    case ({gnt_valid, pop})
      2'b10:   count_nxt = count + (AW + 1)'(1);
      2'b01:   count_nxt = count - (AW + 1)'(1);
      default: count_nxt = count;
    endcase
  end

  assign lost_sum = {1'b0, LOST_CNT} + (LOST_WIDTH + 1)'(drop_n);

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      ptr        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      DATA_VALID <= 1'b0;
      FIFO_FULL  <= 1'b0;
      LOST_CNT   <= '0;
    end else begin
      ptr        <= ptr_nxt;
      count      <= count_nxt;
      DATA_VALID <= (count_nxt != '0);
      FIFO_FULL  <= (count_nxt == (AW + 1)'(FIFO_DEPTH));
      if (gnt_valid) wr_ptr <= wr_ptr + AW'(1);
      if (pop)       rd_ptr <= rd_ptr + AW'(1);
      LOST_CNT   <= lost_sum[LOST_WIDTH] ? '1 : lost_sum[LOST_WIDTH-1:0];
    end
  end

  always_ff @(posedge BUS_CLK) begin
    if (gnt_valid) mem[wr_ptr] <= gnt_word;
  end

  assign DATA_OUT = DATA_VALID ? mem[rd_ptr] : '0;

endmodule
